// File: rtl/mem_bus_responder.sv
// Memory-side responder: services the control unit's active-low MR/MW strobes
// against a byte-wide RAM with programmable wait states and a ready/rvalid handshake.
module mem_bus_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              MR,
  input  logic              MW,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              rvalid,
  output logic              bus_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                rvalid_q, rvalid_d;
  logic                bus_err_q, bus_err_d;
  logic                ram_we;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic start_rd, start_wr, both_low, strobe_held, opp_low;

  assign start_rd    = !MR &&  MW;
  assign start_wr    =  MR && !MW;
  assign both_low    = !MR && !MW;
  // Once an access is latched only its own strobe keeps it alive; the other one is a protocol error.
  assign strobe_held = wr_q ? !MW : !MR;
  assign opp_low     = wr_q ? !MR : !MW;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_rd || start_wr) state_d = ACCESS;
      ACCESS:  if (!strobe_held)         state_d = IDLE;
               else if (cnt_q == 4'd0)   state_d = DONE;
      DONE:    if (!strobe_held)         state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    rvalid_d  = rvalid_q;
    bus_err_d = bus_err_q;
    ram_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (both_low) bus_err_d = 1'b1;
        if (start_rd || start_wr) begin
          addr_d = addr;
          wr_d   = start_wr;
          cnt_d  = WAIT_CNT;
          if (start_wr) wdata_d = wdata;
        end
      end
      ACCESS: begin
        if (opp_low) bus_err_d = 1'b1;
        if (strobe_held) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            ready_d  = 1'b1;
            rvalid_d = !wr_q;
            if (wr_q) ram_we  = 1'b1;
            else      rdata_d = mem[addr_q];
          end
        end
      end
      DONE: begin
        if (opp_low) bus_err_d = 1'b1;
        if (!strobe_held) begin
          ready_d  = 1'b0;
          rvalid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= 4'd0;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      rvalid_q  <= rvalid_d;
      bus_err_q <= bus_err_d;
    end
  end

  // NOTE: the RAM array is deliberately left out of reset so it maps onto plain memory.
  always_ff @(posedge clock) begin
    if (ram_we) mem[addr_q] <= wdata_q;
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign rvalid  = rvalid_q;
  assign bus_err = bus_err_q;
  assign busy    = (state_q != IDLE);

endmodule
